// File: rtl/collatz_panel_pkg.sv
// ============================================================================
// collatz_panel_pkg : shared types and helpers for the Collatz front panel
// Revision 1.0
// ============================================================================
`default_nettype none

package collatz_panel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam int KEY_INC = 0;
    localparam int KEY_DEC = 1;
    localparam int KEY_CLR = 2;
    localparam int KEY_GO  = 3;

    // Largest value representable in the given number of BCD digits.
    function automatic int unsigned bcd_max(input int unsigned digits);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/collatz_panel_ctrl_bcd_serial.sv
// ============================================================================
// bcd_serial : serial shift-add-3 binary to BCD converter, saturating to 9s
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_serial
    import collatz_panel_pkg::*;
#(
    parameter int IN_WIDTH = 12,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [IN_WIDTH-1:0]   din,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int                BW   = 4 * DIGITS;
    localparam int                CW   = $clog2(IN_WIDTH + 1);
    localparam longint unsigned   MAXV = longint'(bcd_max(DIGITS));
    localparam logic [BW-1:0]     ALL9 = {DIGITS{4'h9}};

    logic [IN_WIDTH-1:0] sh_q;
    logic [BW-1:0]       acc_q, acc_adj, acc_next, bcd_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q, valid_q, ovf_pend_q, ovf_q;
    logic                big;

    assign big = (64'(din) > MAXV);

    always_comb begin
        acc_adj = acc_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end
        end
        acc_next = {acc_adj[BW-2:0], sh_q[IN_WIDTH-1]};
    end

    // A load always wins, so a restart mid-conversion simply begins anew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            if (load) begin
                sh_q       <= din;
                acc_q      <= '0;
                cnt_q      <= CW'(IN_WIDTH);
                busy_q     <= 1'b1;
                ovf_pend_q <= big;
            end else if (busy_q) begin
                if (cnt_q != '0) begin
                    acc_q <= acc_next;
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    bcd_q   <= ovf_pend_q ? ALL9 : acc_q;
                    ovf_q   <= ovf_pend_q;
                end
            end
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign bcd   = bcd_q;
    assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/collatz_panel_ctrl.sv
// ============================================================================
// collatz_panel_ctrl : debounced key handling, start value and run handshake
// for the Collatz range engine, with serial BCD display fields.
// Optional macro AUTOREPEAT_EN enables autorepeat on held inc/dec.
// Revision 1.0
// ============================================================================
`default_nettype none

module collatz_panel_ctrl
    import collatz_panel_pkg::*;
#(
    parameter int N_WIDTH      = 12,
    parameter int COUNT_WIDTH  = 16,
    parameter int DIGITS       = 3,
    parameter int N_MAX        = 255,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_CYC   = 10000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              key,
    input  logic [N_WIDTH-1:0]      sw,
    input  logic                    done,
    input  logic [COUNT_WIDTH-1:0]  count,
    output logic                    go,
    output logic [N_WIDTH-1:0]      start,
    output logic                    busy,
    output logic [4*DIGITS-1:0]     n_bcd,
    output logic [4*DIGITS-1:0]     c_bcd,
    output logic                    c_ovf
);

    localparam int                 DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [N_WIDTH-1:0] N_MAX_V = N_WIDTH'(N_MAX);

    logic [1:0]         rst_sync_q;
    logic               rst_int_n;
    logic [3:0]         press_evt;
    logic [3:0]         key_evt;
    state_e             state_q, state_d;
    logic [N_WIDTH-1:0] start_q, start_d;
    logic               c_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

`ifdef AUTOREPEAT_EN
    logic [1:0] held;
`endif

    for (genvar k = 0; k < 4; k++) begin : g_key
        logic [1:0]      sync_q;
        logic            stable_q;
        logic            press_q;
        logic [DB_W-1:0] cnt_q;

        // stable_q is 1 when pressed; the counter only runs while the
        // synchronised sample disagrees with the accepted state.
        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                sync_q   <= 2'b11;
                stable_q <= 1'b0;
                press_q  <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync_q  <= {sync_q[0], key[k]};
                press_q <= 1'b0;
                if (~sync_q[1] != stable_q) begin
                    if (cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                        stable_q <= ~sync_q[1];
                        press_q  <= ~sync_q[1];
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end
        assign press_evt[k] = press_q;
`ifdef AUTOREPEAT_EN
        if (k < 2) begin : g_held
            assign held[k] = stable_q;
        end
`endif
    end

`ifdef AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYC + 1);

    for (genvar r = 0; r < 2; r++) begin : g_rep
        logic [REP_W-1:0] rep_q;
        logic             rep_evt_q;

        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                rep_q     <= '0;
                rep_evt_q <= 1'b0;
            end else begin
                rep_evt_q <= 1'b0;
                if (!held[r]) begin
                    rep_q <= '0;
                end else if (rep_q == REP_W'(REPEAT_CYC - 1)) begin
                    rep_q     <= '0;
                    rep_evt_q <= 1'b1;
                end else begin
                    rep_q <= rep_q + 1'b1;
                end
            end
        end
        assign key_evt[r] = press_evt[r] | rep_evt_q;
    end
    assign key_evt[3:2] = press_evt[3:2];
`else
    assign key_evt = press_evt;
`endif

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        c_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_evt[KEY_GO]) begin
                    start_d = (sw > N_MAX_V) ? N_MAX_V : sw;
                    state_d = LAUNCH;
                end else if (key_evt[KEY_CLR]) begin
                    start_d = '0;
                end else if (key_evt[KEY_INC]) begin
                    if (start_q < N_MAX_V) start_d = start_q + 1'b1;
                end else if (key_evt[KEY_DEC]) begin
                    if (start_q != '0) start_d = start_q - 1'b1;
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                if (done) begin
                    c_load  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign go    = (state_q == LAUNCH);
    assign busy  = (state_q != IDLE);
    assign start = start_q;

    logic n_busy, n_valid, n_ovf, c_busy, c_valid;

    bcd_serial #(.IN_WIDTH(N_WIDTH), .DIGITS(DIGITS)) u_n_bcd (
        .clk   (clk),
        .rst_n (rst_int_n),
        .load  (start_d != start_q),
        .din   (start_d),
        .busy  (n_busy),
        .valid (n_valid),
        .bcd   (n_bcd),
        .ovf   (n_ovf)
    );

    bcd_serial #(.IN_WIDTH(COUNT_WIDTH), .DIGITS(DIGITS)) u_c_bcd (
        .clk   (clk),
        .rst_n (rst_int_n),
        .load  (c_load),
        .din   (count),
        .busy  (c_busy),
        .valid (c_valid),
        .bcd   (c_bcd),
        .ovf   (c_ovf)
    );

    logic unused_status;
    assign unused_status = ^{n_busy, n_valid, n_ovf, c_busy, c_valid};

endmodule

`default_nettype wire

// File: tb/tb_collatz_panel_ctrl.sv
// ============================================================================
// tb_collatz_panel_ctrl : directed self-checking bench for collatz_panel_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_collatz_panel_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key = 4'hF;
    logic [11:0] sw = '0;
    logic        done = 1'b0;
    logic [15:0] count = '0;
    logic        go, busy, c_ovf;
    logic [11:0] start, n_bcd, c_bcd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    collatz_panel_ctrl #(
        .N_WIDTH(12), .COUNT_WIDTH(16), .DIGITS(3), .N_MAX(255),
        .DEBOUNCE_CYC(4), .REPEAT_CYC(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .sw(sw), .done(done),
        .count(count), .go(go), .start(start), .busy(busy),
        .n_bcd(n_bcd), .c_bcd(c_bcd), .c_ovf(c_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx);
        key[idx] = 1'b0;
        repeat (12) tick();
        key[idx] = 1'b1;
        repeat (12) tick();
    endtask

    task automatic settle();
        repeat (20) tick();
    endtask

    task automatic pulse_done(input logic [15:0] cnt);
        count = cnt;
        done  = 1'b1;
        tick();
        done  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (go !== 1'b0)     begin errors++; $display("FAIL reset_go: got %0h expected 0", go); end
        checks++; if (start !== 12'd0) begin errors++; $display("FAIL reset_start: got %0d expected 0", start); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        checks++; if (n_bcd !== 12'h0) begin errors++; $display("FAIL reset_n_bcd: got %0h expected 0", n_bcd); end
        checks++; if (c_bcd !== 12'h0) begin errors++; $display("FAIL reset_c_bcd: got %0h expected 0", c_bcd); end
        checks++; if (c_ovf !== 1'b0)  begin errors++; $display("FAIL reset_c_ovf: got %0h expected 0", c_ovf); end
    endtask

    task automatic test_inc();
        int k;
        press(0);
        press(0);
        key[0] = 1'b0;
        k = 0;
        while (start !== 12'd3 && k < 20) begin tick(); k++; end
        checks++; if (start !== 12'd3) begin errors++; $display("FAIL inc_start: got %0d expected 3", start); end
        k = 0;
        while (n_bcd !== 12'h003 && k < 13) begin tick(); k++; end
        checks++; if (n_bcd !== 12'h003) begin errors++; $display("FAIL inc_n_bcd_13cyc: got %0h expected 003", n_bcd); end
        key[0] = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5; i++) begin
            key[0] = 1'b0; tick(); tick();
            key[0] = 1'b1; tick(); tick();
        end
        press(0);
        checks++; if (start !== 12'd4) begin errors++; $display("FAIL bounce_start: got %0d expected 4", start); end
        settle();
        checks++; if (n_bcd !== 12'h004) begin errors++; $display("FAIL bounce_n_bcd: got %0h expected 004", n_bcd); end
    endtask

    task automatic test_clamp();
        sw = 12'd300;
        press(3);
        checks++; if (start !== 12'd255) begin errors++; $display("FAIL clamp_sw_start: got %0d expected 255", start); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL clamp_busy: got %0h expected 1", busy); end
        pulse_done(16'd5);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL clamp_busy_done: got %0h expected 0", busy); end
        settle();
        checks++; if (n_bcd !== 12'h255) begin errors++; $display("FAIL clamp_n_bcd: got %0h expected 255", n_bcd); end
        checks++; if (c_bcd !== 12'h005) begin errors++; $display("FAIL clamp_c_bcd: got %0h expected 005", c_bcd); end
        press(0);
        checks++; if (start !== 12'd255) begin errors++; $display("FAIL inc_at_max: got %0d expected 255", start); end
        press(2);
        checks++; if (start !== 12'd0)   begin errors++; $display("FAIL clear: got %0d expected 0", start); end
        press(1);
        checks++; if (start !== 12'd0)   begin errors++; $display("FAIL dec_at_zero: got %0d expected 0", start); end
    endtask

    task automatic test_run();
        int k;
        int extra_go;
        sw = 12'd27;
        key[3] = 1'b0;
        k = 0;
        while (go !== 1'b1 && k < 20) begin tick(); k++; end
        checks++; if (go !== 1'b1) begin errors++; $display("FAIL run_go_seen: got %0h expected 1", go); end
        extra_go = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (go === 1'b1) extra_go++; end
        checks++; if (extra_go !== 0)    begin errors++; $display("FAIL run_go_width: got %0d extra cycles expected 0", extra_go); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL run_busy: got %0h expected 1", busy); end
        checks++; if (start !== 12'd27)  begin errors++; $display("FAIL run_start: got %0d expected 27", start); end
        key[3] = 1'b1;
        repeat (12) tick();
        press(0);
        checks++; if (start !== 12'd27)  begin errors++; $display("FAIL run_inc_ignored: got %0d expected 27", start); end
        pulse_done(16'd111);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL run_busy_done: got %0h expected 0", busy); end
        settle();
        checks++; if (c_bcd !== 12'h111) begin errors++; $display("FAIL run_c_bcd: got %0h expected 111", c_bcd); end
        checks++; if (c_ovf !== 1'b0)    begin errors++; $display("FAIL run_c_ovf: got %0h expected 0", c_ovf); end
        checks++; if (n_bcd !== 12'h027) begin errors++; $display("FAIL run_n_bcd: got %0h expected 027", n_bcd); end
    endtask

    task automatic test_ovf();
        press(3);
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL ovf_busy: got %0h expected 1", busy); end
        pulse_done(16'd1000);
        settle();
        checks++; if (c_bcd !== 12'h999) begin errors++; $display("FAIL ovf_c_bcd: got %0h expected 999", c_bcd); end
        checks++; if (c_ovf !== 1'b1)    begin errors++; $display("FAIL ovf_flag: got %0h expected 1", c_ovf); end
    endtask

    task automatic test_done_idle();
        pulse_done(16'd42);
        settle();
        checks++; if (c_bcd !== 12'h999) begin errors++; $display("FAIL idle_done_c_bcd: got %0h expected 999", c_bcd); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL idle_done_busy: got %0h expected 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        sw = 12'd27;
        press(3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %0h expected 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (start !== 12'd0) begin errors++; $display("FAIL midrst_start: got %0d expected 0", start); end
        pulse_done(16'd7);
        settle();
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy: got %0h expected 0", busy); end
        checks++; if (c_bcd !== 12'h0) begin errors++; $display("FAIL midrst_late_done: got %0h expected 000", c_bcd); end
    endtask

    task automatic test_autorepeat();
        logic [11:0] exp_start;
`ifdef AUTOREPEAT_EN
        exp_start = 12'd4;
`else
        exp_start = 12'd1;
`endif
        key[0] = 1'b0;
        repeat (70) tick();
        key[0] = 1'b1;
        repeat (30) tick();
        checks++; if (start !== exp_start) begin errors++; $display("FAIL autorepeat_start: got %0d expected %0d", start, exp_start); end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_bounce();
        test_clamp();
        test_run();
        test_ovf();
        test_done_idle();
        test_reset_mid_run();
        test_autorepeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
